// File: rtl/microseq_cpu_if.sv
// Bus bundle for the microsequenced core: operand input, registered result,
// debug address and read/write strobes.
interface microseq_cpu_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] DATA_I;
   logic [DATA_W-1:0] DATA_O;
   logic [DATA_W-1:0] ADDR;
   logic              RD;
   logic              WR;

   modport master (input DATA_I, output DATA_O, output ADDR, output RD, output WR);
   modport slave  (output DATA_I, input DATA_O, input ADDR, input RD, input WR);
endinterface

// File: rtl/microseq_cpu.sv
// 16-bit microprogrammed datapath: CAR indexes a fixed 16-word control ROM,
// one microword per clock (load, ALU, carry-guarded load, repeated-add multiply).
module microseq_cpu #(
   parameter int DATA_W = 16,
   parameter int CAR_W  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   microseq_cpu_if.master    bus
);

   typedef enum logic [2:0] {ALU_IN, ALU_A, ALU_ADD, ALU_SUB, ALU_ZERO} alu_e;
   typedef enum logic [1:0] {CNT_HOLD, CNT_LOAD, CNT_DEC} cnt_e;
   typedef enum logic       {BR_NEXT, BR_CNTZ} br_e;

   typedef struct packed {
      alu_e             alu;
      logic             we;
      logic [2:0]       dst;
      logic [2:0]       srca;
      logic [2:0]       srcb;
      logic             out_en;
      logic             guard_nc;
      cnt_e             cnt;
      br_e              br;
      logic [CAR_W-1:0] nxt;
      logic [CAR_W-1:0] alt;
      logic             rd;
      logic             wr;
   } uword_t;

   logic [CAR_W-1:0]  CAR;
   logic [DATA_W-1:0] R [0:7];
   logic [DATA_W-1:0] CNT;
   logic              C;

   uword_t            uw;
   logic [DATA_W-1:0] opa, opb, din, alu_y;
   logic [DATA_W:0]   sub_full;
   logic              suppress;
   logic [CAR_W-1:0]  next_car;

   // Control ROM
   always_comb begin
      uw.alu      = ALU_IN;
      uw.we       = 1'b0;
      uw.dst      = 3'd0;
      uw.srca     = 3'd0;
      uw.srcb     = 3'd0;
      uw.out_en   = 1'b0;
      uw.guard_nc = 1'b0;
      uw.cnt      = CNT_HOLD;
      uw.br       = BR_NEXT;
      uw.nxt      = '0;
      uw.alt      = '0;
      uw.rd       = 1'b0;
      uw.wr       = 1'b0;
      case (CAR)
         CAR_W'(0): begin uw.we = 1'b1; uw.dst = 3'd1; uw.out_en = 1'b1; uw.rd = 1'b1; uw.nxt = CAR_W'(1); end
         CAR_W'(1): begin uw.we = 1'b1; uw.dst = 3'd2; uw.out_en = 1'b1; uw.rd = 1'b1; uw.nxt = CAR_W'(2); end
         CAR_W'(2): begin uw.we = 1'b1; uw.dst = 3'd4; uw.out_en = 1'b1; uw.rd = 1'b1; uw.nxt = CAR_W'(3); end
         CAR_W'(3): begin
            uw.alu = ALU_SUB; uw.srca = 3'd1; uw.srcb = 3'd2;
            uw.we = 1'b1; uw.dst = 3'd3; uw.out_en = 1'b1; uw.wr = 1'b1; uw.nxt = CAR_W'(4);
         end
         CAR_W'(4): begin
            uw.we = 1'b1; uw.dst = 3'd5; uw.out_en = 1'b1; uw.guard_nc = 1'b1;
            uw.rd = 1'b1; uw.nxt = CAR_W'(5);
         end
         CAR_W'(5): begin
            uw.alu = ALU_ADD; uw.srca = 3'd1; uw.srcb = 3'd4;
            uw.we = 1'b1; uw.dst = 3'd6; uw.out_en = 1'b1; uw.wr = 1'b1; uw.nxt = CAR_W'(6);
         end
         CAR_W'(6): begin
            uw.alu = ALU_ZERO; uw.srcb = 3'd2; uw.we = 1'b1; uw.dst = 3'd7;
            uw.out_en = 1'b1; uw.cnt = CNT_LOAD; uw.nxt = CAR_W'(7);
         end
         CAR_W'(7): begin uw.br = BR_CNTZ; uw.nxt = CAR_W'(8); uw.alt = CAR_W'(9); end
         CAR_W'(8): begin
            uw.alu = ALU_ADD; uw.srca = 3'd7; uw.srcb = 3'd1;
            uw.we = 1'b1; uw.dst = 3'd7; uw.cnt = CNT_DEC; uw.nxt = CAR_W'(7);
         end
         CAR_W'(9): begin
            uw.alu = ALU_A; uw.srca = 3'd7; uw.out_en = 1'b1; uw.wr = 1'b1; uw.nxt = CAR_W'(0);
         end
         default: uw.nxt = CAR_W'(0);
      endcase
   end

   assign opa      = R[uw.srca];
   assign opb      = R[uw.srcb];
   assign din      = uw.rd ? bus.DATA_I : '0;
   assign sub_full = {1'b0, opa} - {1'b0, opb};
   // Carry-guarded microword: a set borrow kills the register write and forces a zero result.
   assign suppress = uw.guard_nc & C;

   always_comb begin
      alu_y = '0;
      case (uw.alu)
         ALU_IN:   alu_y = din;
         ALU_A:    alu_y = opa;
         ALU_ADD:  alu_y = opa + opb;
         ALU_SUB:  alu_y = sub_full[DATA_W-1:0];
         ALU_ZERO: alu_y = '0;
         default:  alu_y = '0;
      endcase
   end

   always_comb begin
      next_car = uw.nxt;
      if (uw.br == BR_CNTZ && CNT == '0) next_car = uw.alt;
   end

   assign bus.ADDR = {{(DATA_W-CAR_W){1'b0}}, CAR};
   assign bus.RD   = uw.rd;
   assign bus.WR   = uw.wr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         CAR        <= '0;
         CNT        <= '0;
         C          <= 1'b0;
         bus.DATA_O <= '0;
         for (int unsigned i = 0; i < 8; i++) R[i] <= '0;
      end else begin
         CAR <= next_car;
         if (uw.we && !suppress) R[uw.dst] <= alu_y;
         if (uw.out_en)          bus.DATA_O <= suppress ? '0 : alu_y;
         if (uw.alu == ALU_SUB)  C <= sub_full[DATA_W];
         case (uw.cnt)
            CNT_LOAD: CNT <= opb;
            CNT_DEC:  CNT <= CNT - 1'b1;
            default:  CNT <= CNT;
         endcase
      end
   end

endmodule

// File: tb/tb_microseq_cpu.sv
// Directed self-checking bench for microseq_cpu: loads, subtract/borrow,
// carry-guarded load, add, repeated-add multiply and asynchronous reset.
module tb_microseq_cpu;

   logic CLK;
   logic RST;
   int   vectors;
   int   miscompares;

   microseq_cpu_if #(.DATA_W(16)) bus ();

   microseq_cpu #(.DATA_W(16), .CAR_W(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input logic [15:0] d);
      bus.DATA_I = d;
      @(posedge CLK);
      #1;
   endtask

   task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      step(a);
      step(b);
      step(c);
   endtask

   task automatic test_reset;
      RST = 1'b1;
      bus.DATA_I = 16'h0000;
      repeat (2) @(posedge CLK);
      #1;
      vectors++; if (dut.CAR !== 4'd0) begin miscompares++; $display("FAIL rst_car: got %0d want 0", dut.CAR); end
      vectors++; if (bus.DATA_O !== 16'h0000) begin miscompares++; $display("FAIL rst_data: got %h want 0000", bus.DATA_O); end
      vectors++; if (bus.RD !== 1'b1) begin miscompares++; $display("FAIL rst_rd: got %b want 1", bus.RD); end
      vectors++; if (bus.WR !== 1'b0) begin miscompares++; $display("FAIL rst_wr: got %b want 0", bus.WR); end
      vectors++; if (bus.ADDR !== 16'h0000) begin miscompares++; $display("FAIL rst_addr: got %h want 0000", bus.ADDR); end
      RST = 1'b0;
   endtask

   task automatic test_load;
      step(16'h0004);
      vectors++; if (bus.DATA_O !== 16'h0004) begin miscompares++; $display("FAIL load0: got %h want 0004", bus.DATA_O); end
      vectors++; if (bus.ADDR !== 16'h0001) begin miscompares++; $display("FAIL load0_addr: got %h want 0001", bus.ADDR); end
      step(16'h0002);
      vectors++; if (bus.DATA_O !== 16'h0002) begin miscompares++; $display("FAIL load1: got %h want 0002", bus.DATA_O); end
      step(16'h0007);
      vectors++; if (bus.DATA_O !== 16'h0007) begin miscompares++; $display("FAIL load2: got %h want 0007", bus.DATA_O); end
      vectors++; if (dut.CAR !== 4'd3) begin miscompares++; $display("FAIL load2_car: got %0d want 3", dut.CAR); end
   endtask

   task automatic test_alu;
      vectors++; if (bus.WR !== 1'b1) begin miscompares++; $display("FAIL sub_wr: got %b want 1", bus.WR); end
      vectors++; if (bus.RD !== 1'b0) begin miscompares++; $display("FAIL sub_rd: got %b want 0", bus.RD); end
      step(16'h0005);
      vectors++; if (bus.DATA_O !== 16'h0002) begin miscompares++; $display("FAIL sub: got %h want 0002", bus.DATA_O); end
      vectors++; if (dut.C !== 1'b0) begin miscompares++; $display("FAIL sub_c: got %b want 0", dut.C); end
      vectors++; if (dut.R[3] !== 16'h0002) begin miscompares++; $display("FAIL sub_r3: got %h want 0002", dut.R[3]); end
      vectors++; if (bus.RD !== 1'b1) begin miscompares++; $display("FAIL chk_rd: got %b want 1", bus.RD); end
      step(16'h0005);
      vectors++; if (bus.DATA_O !== 16'h0005) begin miscompares++; $display("FAIL pass: got %h want 0005", bus.DATA_O); end
      vectors++; if (dut.R[5] !== 16'h0005) begin miscompares++; $display("FAIL pass_r5: got %h want 0005", dut.R[5]); end
      step(16'hFFFF);
      vectors++; if (bus.DATA_O !== 16'h000B) begin miscompares++; $display("FAIL add: got %h want 000B", bus.DATA_O); end
   endtask

   task automatic test_multiply;
      logic [3:0] exp_car [6] = '{4'd8, 4'd7, 4'd8, 4'd7, 4'd9, 4'd0};
      step(16'h0001);
      vectors++; if (bus.DATA_O !== 16'h0000) begin miscompares++; $display("FAIL mstart: got %h want 0000", bus.DATA_O); end
      vectors++; if (dut.CNT !== 16'h0002) begin miscompares++; $display("FAIL mstart_cnt: got %h want 0002", dut.CNT); end
      vectors++; if (dut.CAR !== 4'd7) begin miscompares++; $display("FAIL mstart_car: got %0d want 7", dut.CAR); end
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            vectors++; if (bus.WR !== 1'b1) begin miscompares++; $display("FAIL mout_wr: got %b want 1", bus.WR); end
         end
         step(16'hAAAA);
         vectors++; if (dut.CAR !== exp_car[i]) begin miscompares++; $display("FAIL mseq[%0d]: got %0d want %0d", i, dut.CAR, exp_car[i]); end
      end
      vectors++; if (bus.DATA_O !== 16'h0008) begin miscompares++; $display("FAIL mprod: got %h want 0008", bus.DATA_O); end
   endtask

   task automatic test_borrow;
      int n;
      load3(16'h0002, 16'h0005, 16'h0003);
      step(16'h0000);
      vectors++; if (bus.DATA_O !== 16'hFFFD) begin miscompares++; $display("FAIL bsub: got %h want FFFD", bus.DATA_O); end
      vectors++; if (dut.C !== 1'b1) begin miscompares++; $display("FAIL bsub_c: got %b want 1", dut.C); end
      step(16'h1234);
      vectors++; if (bus.DATA_O !== 16'h0000) begin miscompares++; $display("FAIL bguard: got %h want 0000", bus.DATA_O); end
      vectors++; if (dut.R[5] !== 16'h0005) begin miscompares++; $display("FAIL bguard_r5: got %h want 0005", dut.R[5]); end
      step(16'h0000);
      vectors++; if (bus.DATA_O !== 16'h0005) begin miscompares++; $display("FAIL badd: got %h want 0005", bus.DATA_O); end
      n = 0;
      do begin step(16'h0000); n++; end while (dut.CAR != 4'd0 && n < 200);
      vectors++; if (n !== 13) begin miscompares++; $display("FAIL bmul_cycles: got %0d want 13", n); end
      vectors++; if (bus.DATA_O !== 16'h000A) begin miscompares++; $display("FAIL bmul: got %h want 000A", bus.DATA_O); end
   endtask

   task automatic test_zero_mult;
      load3(16'h0003, 16'h0000, 16'h0001);
      step(16'h0000);
      vectors++; if (bus.DATA_O !== 16'h0003) begin miscompares++; $display("FAIL zsub: got %h want 0003", bus.DATA_O); end
      vectors++; if (dut.C !== 1'b0) begin miscompares++; $display("FAIL zsub_c: got %b want 0", dut.C); end
      step(16'h0009);
      vectors++; if (bus.DATA_O !== 16'h0009) begin miscompares++; $display("FAIL zpass: got %h want 0009", bus.DATA_O); end
      step(16'h0000);
      vectors++; if (bus.DATA_O !== 16'h0004) begin miscompares++; $display("FAIL zadd: got %h want 0004", bus.DATA_O); end
      step(16'h0000);
      vectors++; if (dut.CAR !== 4'd7) begin miscompares++; $display("FAIL zpath7: got %0d want 7", dut.CAR); end
      step(16'h0000);
      vectors++; if (dut.CAR !== 4'd9) begin miscompares++; $display("FAIL zpath9: got %0d want 9", dut.CAR); end
      step(16'h0000);
      vectors++; if (dut.CAR !== 4'd0) begin miscompares++; $display("FAIL zpath0: got %0d want 0", dut.CAR); end
      vectors++; if (bus.DATA_O !== 16'h0000) begin miscompares++; $display("FAIL zprod: got %h want 0000", bus.DATA_O); end
   endtask

   task automatic test_wrap;
      int n;
      load3(16'hFFFF, 16'h0003, 16'h0002);
      step(16'h0000);
      vectors++; if (bus.DATA_O !== 16'hFFFC) begin miscompares++; $display("FAIL wsub: got %h want FFFC", bus.DATA_O); end
      step(16'h0055);
      vectors++; if (bus.DATA_O !== 16'h0055) begin miscompares++; $display("FAIL wpass: got %h want 0055", bus.DATA_O); end
      step(16'h0000);
      vectors++; if (bus.DATA_O !== 16'h0001) begin miscompares++; $display("FAIL wadd: got %h want 0001", bus.DATA_O); end
      n = 0;
      do begin step(16'h0000); n++; end while (dut.CAR != 4'd0 && n < 200);
      vectors++; if (n !== 9) begin miscompares++; $display("FAIL wmul_cycles: got %0d want 9", n); end
      vectors++; if (bus.DATA_O !== 16'hFFFD) begin miscompares++; $display("FAIL wmul: got %h want FFFD", bus.DATA_O); end
   endtask

   task automatic test_reset_mid;
      int nz;
      load3(16'h0003, 16'h0004, 16'h0001);
      repeat (5) step(16'h0000);
      vectors++; if (dut.CAR !== 4'd8) begin miscompares++; $display("FAIL mid_pre_car: got %0d want 8", dut.CAR); end
      #2;
      RST = 1'b1;
      #1;
      vectors++; if (dut.CAR !== 4'd0) begin miscompares++; $display("FAIL mid_car: got %0d want 0", dut.CAR); end
      vectors++; if (bus.DATA_O !== 16'h0000) begin miscompares++; $display("FAIL mid_data: got %h want 0000", bus.DATA_O); end
      vectors++; if (dut.C !== 1'b0) begin miscompares++; $display("FAIL mid_c: got %b want 0", dut.C); end
      vectors++; if (dut.CNT !== 16'h0000) begin miscompares++; $display("FAIL mid_cnt: got %h want 0000", dut.CNT); end
      nz = 0;
      for (int i = 0; i < 8; i++) if (dut.R[i] !== 16'h0000) nz++;
      vectors++; if (nz !== 0) begin miscompares++; $display("FAIL mid_regs: %0d nonzero registers want 0", nz); end
      @(posedge CLK);
      #1;
      RST = 1'b0;
      step(16'h0006);
      vectors++; if (bus.DATA_O !== 16'h0006) begin miscompares++; $display("FAIL restart: got %h want 0006", bus.DATA_O); end
      vectors++; if (dut.CAR !== 4'd1) begin miscompares++; $display("FAIL restart_car: got %0d want 1", dut.CAR); end
      vectors++; if (dut.R[1] !== 16'h0006) begin miscompares++; $display("FAIL restart_r1: got %h want 0006", dut.R[1]); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RST         = 1'b1;
      bus.DATA_I  = 16'h0000;
      test_reset();
      test_load();
      test_alu();
      test_multiply();
      test_borrow();
      test_zero_mult();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
